mem_port_arbiter: RTL and testbench

Shares the single-port, byte-wide 64 KiB program/data memory between two requesters: the processor core (port C) and the program loader / IO DMA engine (port L). Each granted request is an 8-bit or 16-bit little-endian read or write. The arbiter sequences a 16-bit access as two byte cycles on the memory. Sits between the requesters and the memory array, replacing direct array indexing by the core.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared byte-wide program/data memory
//
// Purpose: grants the core (c_*) or the loader/DMA (l_*) access to a single-port
// byte memory and sequences 8-bit or 16-bit little-endian reads and writes as
// one or two byte cycles. Ties go to the port that was not granted last.
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   x_valid/x_we/x_wide/x_addr     request (x = c core, l loader); held until x_ready
//   x_wdata                        write data, low byte to addr, high byte to addr+1
//   x_ready                        request accepted on x_valid && x_ready
//   x_rs_valid/x_rs_rdata          one-cycle completion pulse and read result
//   mem_addr/mem_we/mem_wdata      memory byte interface, driven only in byte cycles
//   mem_rdata                      memory read byte, valid the cycle after mem_addr
//   busy                           FSM not idle

module mem_port_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                c_valid,
   input  logic                c_we,
   input  logic                c_wide,
   input  logic [ADDR_W-1:0]   c_addr,
   input  logic [2*DATA_W-1:0] c_wdata,
   output logic                c_ready,
   output logic                c_rs_valid,
   output logic [2*DATA_W-1:0] c_rs_rdata,
   input  logic                l_valid,
   input  logic                l_we,
   input  logic                l_wide,
   input  logic [ADDR_W-1:0]   l_addr,
   input  logic [2*DATA_W-1:0] l_wdata,
   output logic                l_ready,
   output logic                l_rs_valid,
   output logic [2*DATA_W-1:0] l_rs_rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_B0   = 2'd1;
   localparam logic [1:0] ST_B1   = 2'd2;
   localparam logic [1:0] ST_CAP  = 2'd3;

   logic [1:0]          state;
   logic                last_l;    // 1 = loader was granted last
   logic                own_l;     // owner of the transaction in flight
   logic                r_we;
   logic                r_wide;
   logic [ADDR_W-1:0]   r_addr;
   logic [2*DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0]   lo_byte;   // low read byte of a wide access
   logic [2*DATA_W-1:0] cap_data;
   logic                idle;

   assign idle = (state == ST_IDLE);
   assign busy = !idle;

   // Only the winner sees ready; on a tie the port not granted last wins.
   assign c_ready = idle && !rst && c_valid && (!l_valid || last_l);
   assign l_ready = idle && !rst && l_valid && (!c_valid || !last_l);

   // In CAP, mem_rdata holds the byte addressed in the previous cycle:
   // the only byte of a narrow read or the high byte of a wide one.
   assign cap_data = r_wide ? {mem_rdata, lo_byte} : {{DATA_W{1'b0}}, mem_rdata};

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         ST_B0: begin
            mem_we    = r_we;
            mem_addr  = r_addr;
            mem_wdata = r_wdata[DATA_W-1:0];
         end
         ST_B1: begin
            mem_we    = r_we;
            mem_addr  = r_addr + ADDR_W'(1);
            mem_wdata = r_wdata[2*DATA_W-1:DATA_W];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_l     <= 1'b1;
         own_l      <= 1'b0;
         r_we       <= 1'b0;
         r_wide     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         lo_byte    <= '0;
         c_rs_valid <= 1'b0;
         l_rs_valid <= 1'b0;
         c_rs_rdata <= '0;
         l_rs_rdata <= '0;
      end else begin
         c_rs_valid <= 1'b0;
         l_rs_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (c_ready || l_ready) begin
                  own_l   <= l_ready;
                  last_l  <= l_ready;
                  r_we    <= l_ready ? l_we    : c_we;
                  r_wide  <= l_ready ? l_wide  : c_wide;
                  r_addr  <= l_ready ? l_addr  : c_addr;
                  r_wdata <= l_ready ? l_wdata : c_wdata;
                  state   <= ST_B0;
               end
            end
            ST_B0: begin
               state <= r_wide ? ST_B1 : ST_CAP;
            end
            ST_B1: begin
               if (!r_we) lo_byte <= mem_rdata;
               state <= ST_CAP;
            end
            default: begin
               if (own_l) begin
                  l_rs_valid <= 1'b1;
                  if (!r_we) l_rs_rdata <= cap_data;
               end else begin
                  c_rs_valid <= 1'b1;
                  if (!r_we) c_rs_rdata <= cap_data;
               end
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction-level model

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_valid, c_we, c_wide, l_valid, l_we, l_wide;
   logic [15:0] c_addr, c_wdata, l_addr, l_wdata;
   logic        c_ready, c_rs_valid, l_ready, l_rs_valid;
   logic [15:0] c_rs_rdata, l_rs_rdata;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .c_valid(c_valid), .c_we(c_we), .c_wide(c_wide), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ready(c_ready), .c_rs_valid(c_rs_valid), .c_rs_rdata(c_rs_rdata),
      .l_valid(l_valid), .l_we(l_we), .l_wide(l_wide), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_ready(l_ready), .l_rs_valid(l_rs_valid), .l_rs_rdata(l_rs_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 37) ^ (i >> 8));
   endfunction

   // physical memory seen by the DUT
   logic [7:0]  mem [0:65535];
   bit          mem_init = 1'b0;
   logic        poke_en = 1'b0;
   logic [15:0] poke_a = 16'h0;
   logic [7:0]  poke_d = 8'h0;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 65536; i++) mem[i] <= pat(i);
         mem_init <= 1'b1;
      end
      if (poke_en) mem[poke_a] <= poke_d;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level reference: a transaction occupies one cycle per byte,
   // one capture cycle, and completes in the cycle the arbiter is idle again.
   logic [7:0]  ref_mem [0:65535];
   bit          ref_init = 1'b0;
   bit          m_active, m_own_l, m_we, m_wide;
   bit          m_last_l = 1'b1;
   bit          m_rsp_c, m_rsp_l, m_acc_c, m_acc_l;
   int          m_k;
   logic [15:0] m_addr, m_wdata, m_exp;
   logic [15:0] m_rd_c = 16'h0;
   logic [15:0] m_rd_l = 16'h0;

   function automatic bit e_ready(input bit is_l);
      if (m_active || rst) return 1'b0;
      if (is_l) return l_valid && (!c_valid || !m_last_l);
      return c_valid && (!l_valid || m_last_l);
   endfunction

   task automatic m_take(input bit is_l);
      m_active = 1'b1;
      m_k      = 1;
      m_own_l  = is_l;
      m_last_l = is_l;
      m_we     = is_l ? l_we    : c_we;
      m_wide   = is_l ? l_wide  : c_wide;
      m_addr   = is_l ? l_addr  : c_addr;
      m_wdata  = is_l ? l_wdata : c_wdata;
      m_exp    = m_wide ? {ref_mem[m_addr + 16'd1], ref_mem[m_addr]} : {8'h00, ref_mem[m_addr]};
      if (is_l) m_acc_l = 1'b1; else m_acc_c = 1'b1;
   endtask

   initial begin
      int nb;
      forever begin
         @(posedge clk or posedge rst);
         if (!ref_init) begin
            for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
            ref_init = 1'b1;
         end
         if (poke_en) ref_mem[poke_a] = poke_d;
         m_acc_c = 1'b0;
         m_acc_l = 1'b0;
         if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_last_l = 1'b1;
            m_rsp_c  = 1'b0;
            m_rsp_l  = 1'b0;
            m_rd_c   = 16'h0;
            m_rd_l   = 16'h0;
         end else begin
            m_rsp_c = 1'b0;
            m_rsp_l = 1'b0;
            if (!m_active) begin
               if (e_ready(1'b0)) m_take(1'b0);
               else if (e_ready(1'b1)) m_take(1'b1);
            end else begin
               nb = m_wide ? 2 : 1;
               if (m_we && m_k <= nb)
                  ref_mem[m_addr + 16'(m_k - 1)] = (m_k == 1) ? m_wdata[7:0] : m_wdata[15:8];
               m_k++;
               if (m_k == nb + 2) begin
                  m_active = 1'b0;
                  if (m_own_l) begin
                     m_rsp_l = 1'b1;
                     if (!m_we) m_rd_l = m_exp;
                  end else begin
                     m_rsp_c = 1'b1;
                     if (!m_we) m_rd_c = m_exp;
                  end
               end
            end
         end
      end
   end

   // per-cycle comparison of every output against the model
   initial begin
      int nb;
      bit inb;
      logic [15:0] ea;
      logic [7:0] ed;
      forever begin
         @(negedge clk);
         if (ref_init) begin
            nb  = m_wide ? 2 : 1;
            inb = m_active && (m_k <= nb);
            ea  = inb ? m_addr + 16'(m_k - 1) : 16'h0;
            ed  = inb ? ((m_k == 1) ? m_wdata[7:0] : m_wdata[15:8]) : 8'h0;
            chk("busy",       32'(busy),       32'(m_active));
            chk("mem_we",     32'(mem_we),     32'(inb && m_we));
            chk("mem_addr",   32'(mem_addr),   32'(ea));
            chk("mem_wdata",  32'(mem_wdata),  32'(ed));
            chk("c_ready",    32'(c_ready),    32'(e_ready(1'b0)));
            chk("l_ready",    32'(l_ready),    32'(e_ready(1'b1)));
            chk("c_rs_valid", 32'(c_rs_valid), 32'(m_rsp_c));
            chk("l_rs_valid", 32'(l_rs_valid), 32'(m_rsp_l));
            chk("c_rs_rdata", 32'(c_rs_rdata), 32'(m_rd_c));
            chk("l_rs_rdata", 32'(l_rs_rdata), 32'(m_rd_l));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      poke_a  = a;
      poke_d  = d;
      poke_en = 1'b1;
      step();
      poke_en = 1'b0;
   endtask

   function automatic logic [15:0] raddr();
      case ($urandom_range(0, 3))
         0:       return 16'($urandom_range(0, 15));
         1:       return 16'hFFFF;
         2:       return 16'hFFFE;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic new_req(input bit is_l);
      if (is_l) begin
         l_valid = 1'b1; l_we = 1'($urandom); l_wide = 1'($urandom);
         l_addr = raddr(); l_wdata = 16'($urandom);
      end else begin
         c_valid = 1'b1; c_we = 1'($urandom); c_wide = 1'($urandom);
         c_addr = raddr(); c_wdata = 16'($urandom);
      end
   endtask

   int gseq [16];
   int gcyc [16];

   initial begin
      int ng, nc, nl, nmis;
      bit acc_c, acc_l;
      c_valid = 0; c_we = 0; c_wide = 0; c_addr = 0; c_wdata = 0;
      l_valid = 0; l_we = 0; l_wide = 0; l_addr = 0; l_wdata = 0;

      // reset state, then tie priority after release
      repeat (3) step();
      chk("rst_busy",  32'(busy),     32'd0);
      chk("rst_maddr", 32'(mem_addr), 32'd0);
      chk("rst_c_rd",  32'(c_rs_rdata), 32'd0);
      c_valid = 1'b1; l_valid = 1'b1;
      rst = 1'b0;
      #1;
      chk("tie_c_ready", 32'(c_ready), 32'd1);
      chk("tie_l_ready", 32'(l_ready), 32'd0);
      @(negedge clk);
      #1;
      c_valid = 1'b0; l_valid = 1'b0;
      step();

      // narrow read by the core
      poke(16'h0010, 8'h5A);
      c_we = 0; c_wide = 0; c_addr = 16'h0010; c_valid = 1'b1;
      #1 chk("nr_ready", 32'(c_ready), 32'd1);
      step(); c_valid = 1'b0;
      chk("nr_maddr", 32'(mem_addr), 32'h0010);
      step(); step();
      chk("nr_rsv",  32'(c_rs_valid), 32'd1);
      chk("nr_data", 32'(c_rs_rdata), 32'h005A);

      // wide write across the top of the address space, then read it back
      l_we = 1; l_wide = 1; l_addr = 16'hFFFF; l_wdata = 16'hBEEF; l_valid = 1'b1;
      step(); l_valid = 1'b0;
      chk("ww_addr0", 32'(mem_addr), 32'hFFFF);
      chk("ww_we0",   32'(mem_we),   32'd1);
      chk("ww_data0", 32'(mem_wdata), 32'hEF);
      step();
      chk("ww_addr1", 32'(mem_addr), 32'h0000);
      chk("ww_data1", 32'(mem_wdata), 32'hBE);
      chk("ww_mem_ffff", 32'(mem[16'hFFFF]), 32'hEF);
      step(); step();
      chk("ww_rsv", 32'(l_rs_valid), 32'd1);
      chk("ww_mem_0000", 32'(mem[16'h0000]), 32'hBE);
      l_we = 0; l_wide = 1; l_addr = 16'hFFFF; l_valid = 1'b1;
      step(); l_valid = 1'b0;
      step(); step(); step();
      chk("wr_rsv",  32'(l_rs_valid), 32'd1);
      chk("wr_data", 32'(l_rs_rdata), 32'hBEEF);

      // contention: both ports hold valid for four narrow reads each
      ng = 0; nc = 0; nl = 0;
      c_we = 0; c_wide = 0; c_addr = 16'h0020; c_valid = 1'b1;
      l_we = 0; l_wide = 0; l_addr = 16'h0040; l_valid = 1'b1;
      for (int cy = 0; cy < 60 && (nc < 4 || nl < 4); cy++) begin
         @(negedge clk);
         acc_c = c_valid && c_ready;
         acc_l = l_valid && l_ready;
         if (acc_c && ng < 16) begin gseq[ng] = 0; gcyc[ng] = cy; ng++; end
         if (acc_l && ng < 16) begin gseq[ng] = 1; gcyc[ng] = cy; ng++; end
         step();
         if (acc_c) begin nc++; c_addr = 16'h0020 + 16'(nc); if (nc == 4) c_valid = 1'b0; end
         if (acc_l) begin nl++; l_addr = 16'h0040 + 16'(nl); if (nl == 4) l_valid = 1'b0; end
      end
      c_valid = 1'b0; l_valid = 1'b0;
      chk("cont_count", 32'(ng), 32'd8);
      for (int i = 0; i < ng && i < 16; i++) begin
         chk("cont_who", 32'(gseq[i]), 32'(i % 2));
         if (i > 0) chk("cont_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
      end
      repeat (4) step();

      // reset during the second byte of a wide write
      poke(16'h0100, 8'h00);
      poke(16'h0101, 8'h00);
      l_we = 1; l_wide = 1; l_addr = 16'h0100; l_wdata = 16'h1234; l_valid = 1'b1;
      step(); l_valid = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      chk("ar_busy",  32'(busy),       32'd0);
      chk("ar_we",    32'(mem_we),     32'd0);
      chk("ar_addr",  32'(mem_addr),   32'd0);
      chk("ar_wdata", 32'(mem_wdata),  32'd0);
      chk("ar_lrsv",  32'(l_rs_valid), 32'd0);
      chk("ar_crsv",  32'(c_rs_valid), 32'd0);
      chk("ar_lrd",   32'(l_rs_rdata), 32'd0);
      chk("ar_crd",   32'(c_rs_rdata), 32'd0);
      step();
      rst = 1'b0;
      chk("ar_mem_lo", 32'(mem[16'h0100]), 32'h34);
      chk("ar_mem_hi", 32'(mem[16'h0101]), 32'h00);
      l_we = 0; l_wide = 0; l_addr = 16'h0100; l_valid = 1'b1;
      #1 chk("ar_next_ready", 32'(l_ready), 32'd1);
      step(); l_valid = 1'b0;
      step(); step();
      chk("ar_next_rsv",  32'(l_rs_valid), 32'd1);
      chk("ar_next_data", 32'(l_rs_rdata), 32'h0034);

      // back-to-back narrow reads from the core with valid held
      c_we = 0; c_wide = 0; c_addr = 16'h0030; c_valid = 1'b1;
      for (int cy = 0; cy < 15; cy++) begin
         @(negedge clk);
         chk("b2b_ready", 32'(c_ready), 32'(cy % 3 == 0));
         chk("b2b_busy",  32'(busy),    32'(cy % 3 != 0));
         step();
         if (cy % 3 == 0) c_addr = c_addr + 16'd1;
      end
      c_valid = 1'b0;
      repeat (4) step();

      // randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 4000; n++) begin
         step();
         if (!c_valid || m_acc_c) begin
            if ($urandom_range(0, 2) != 0) new_req(1'b0); else c_valid = 1'b0;
         end
         if (!l_valid || m_acc_l) begin
            if ($urandom_range(0, 2) != 0) new_req(1'b1); else l_valid = 1'b0;
         end
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b1;
            step();
            rst = 1'b0;
         end
      end
      c_valid = 1'b0; l_valid = 1'b0;
      repeat (6) step();

      nmis = 0;
      for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) nmis++;
      chk("mem_final", 32'(nmis), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
